// File: rtl/sargantana_icache_way_writer.sv
// -----------------------------------------------------------------------------
// sargantana_icache_way_writer
//
// Write-side initiator for the instruction-cache data ways. A refill line is
// collected from the memory side as BEAT_WIDTH-bit beats (beat 0 lands in the
// least significant slice), then written in a single cycle to every way whose
// bit is set in the latched mask. A flush request runs a sweep that writes
// zero to every set of every way.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   fill_start_i           start a refill (honoured only while ready_o=1)
//   fill_addr_i/fill_way_i set index and way mask, sampled with fill_start_i
//   beat_valid_i/beat_data_i/beat_ready_o   refill beat handshake
//   kill_i                 abort a refill that is still collecting beats
//   flush_i                request a zeroing sweep of all sets of all ways
//   ready_o                idle, a new fill_start_i is accepted
//   way_req_o/way_we_o     per-way request / write enable
//   way_addr_o/way_data_o  set index / line data shared by all ways
//   fill_done_o            one-cycle pulse on the line write
//   flush_done_o           one-cycle pulse on the last flush write
// -----------------------------------------------------------------------------
module sargantana_icache_way_writer #(
    parameter int ICACHE_DEPTH = 64,
    parameter int SET_WIDHT    = 256,
    parameter int ADDR_WIDHT   = 6,
    parameter int BEAT_WIDTH   = 64,
    parameter int WAYS         = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  fill_start_i,
    input  logic [ADDR_WIDHT-1:0] fill_addr_i,
    input  logic [WAYS-1:0]       fill_way_i,
    input  logic                  beat_valid_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    output logic                  beat_ready_o,
    input  logic                  kill_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic [WAYS-1:0]       way_req_o,
    output logic [WAYS-1:0]       way_we_o,
    output logic [ADDR_WIDHT-1:0] way_addr_o,
    output logic [SET_WIDHT-1:0]  way_data_o,
    output logic                  fill_done_o,
    output logic                  flush_done_o
);

    localparam int NBEATS = SET_WIDHT / BEAT_WIDTH;
    localparam int BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDHT-1:0]   fill_addr_q;
    logic [WAYS-1:0]         fill_way_q;
    logic [BCNT_W-1:0]       beat_cnt_q;
    logic [ADDR_WIDHT-1:0]   flush_cnt_q;
    logic [SET_WIDHT-1:0]    line_q;
    logic                    flush_pend_q;
    // Last address/data driven to the ways, so the shared bus stays stable
    // while the writer is idle or collecting.
    logic [ADDR_WIDHT-1:0]   hold_addr_q;
    logic [SET_WIDHT-1:0]    hold_data_q;

    logic                    flush_req;
    logic                    fill_accept;
    logic                    beat_accept;
    logic                    beat_last;
    logic                    flush_last;
    logic [NBEATS-1:0]       beat_slot_we;

    // A pending or fresh flush always beats a simultaneous fill_start_i.
    assign flush_req   = flush_i | flush_pend_q;
    assign fill_accept = (state_q == S_IDLE) & fill_start_i & ~flush_req;
    // kill_i takes priority over a beat presented in the same cycle.
    assign beat_accept = (state_q == S_COLLECT) & beat_valid_i & ~kill_i;
    assign beat_last   = (beat_cnt_q == BCNT_W'(NBEATS - 1));
    assign flush_last  = (flush_cnt_q == ADDR_WIDHT'(ICACHE_DEPTH - 1));

    // One write strobe per beat slot of the line buffer.
    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_slot_we
            assign beat_slot_we[gi] = beat_accept & (beat_cnt_q == BCNT_W'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (fill_start_i) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else if (beat_accept && beat_last) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (flush_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ready_o      = 1'b0;
        beat_ready_o = 1'b0;
        way_req_o    = '0;
        way_we_o     = '0;
        way_addr_o   = hold_addr_q;
        way_data_o   = hold_data_q;
        fill_done_o  = 1'b0;
        flush_done_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
            end
            S_COLLECT: begin
                beat_ready_o = 1'b1;
            end
            S_WRITE: begin
                // Mask used verbatim: an all-zero mask still reports completion.
                way_req_o   = fill_way_q;
                way_we_o    = fill_way_q;
                way_addr_o  = fill_addr_q;
                way_data_o  = line_q;
                fill_done_o = 1'b1;
            end
            S_FLUSH: begin
                way_req_o    = '1;
                way_we_o     = '1;
                way_addr_o   = flush_cnt_q;
                way_data_o   = '0;
                flush_done_o = flush_last;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fill_addr_q  <= '0;
            fill_way_q   <= '0;
            beat_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
        end else begin
            if (fill_accept) begin
                fill_addr_q <= fill_addr_i;
                fill_way_q  <= fill_way_i;
                beat_cnt_q  <= '0;
            end else if (beat_accept) begin
                beat_cnt_q  <= beat_cnt_q + 1'b1;
            end

            for (int i = 0; i < NBEATS; i++) begin
                if (beat_slot_we[i]) begin
                    line_q[i*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
                end
            end

            // FLUSH is only ever entered from IDLE, which consumes the pending
            // request; any flush_i seen elsewhere (including during a sweep)
            // queues exactly one further sweep.
            if (state_q == S_IDLE) begin
                flush_pend_q <= 1'b0;
            end else begin
                flush_pend_q <= flush_pend_q | flush_i;
            end

            if (state_q == S_IDLE) begin
                flush_cnt_q <= '0;
            end else if (state_q == S_FLUSH) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end

            if ((state_q == S_WRITE) || (state_q == S_FLUSH)) begin
                hold_addr_q <= way_addr_o;
                hold_data_q <= way_data_o;
            end
        end
    end

endmodule

// File: tb/tb_sargantana_icache_way_writer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sargantana_icache_way_writer. A monitor records every
// cycle in which the writer touches the ways or pulses a done flag; each test
// task compares that record against writes predicted from the block's rules
// (line = beats placed by index, write one cycle after the last beat, sweeps of
// DEPTH consecutive zero writes).
// -----------------------------------------------------------------------------
module tb_sargantana_icache_way_writer;

    localparam int DEPTH = 64;
    localparam int SW    = 256;
    localparam int AW    = 6;
    localparam int BW    = 64;
    localparam int WAYS  = 4;
    localparam int NB    = SW / BW;

    logic            clk = 1'b0;
    logic            rstn_i = 1'b0;
    logic            fill_start_i = 1'b0;
    logic [AW-1:0]   fill_addr_i = '0;
    logic [WAYS-1:0] fill_way_i = '0;
    logic            beat_valid_i = 1'b0;
    logic [BW-1:0]   beat_data_i = '0;
    logic            beat_ready_o;
    logic            kill_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            ready_o;
    logic [WAYS-1:0] way_req_o;
    logic [WAYS-1:0] way_we_o;
    logic [AW-1:0]   way_addr_o;
    logic [SW-1:0]   way_data_o;
    logic            fill_done_o;
    logic            flush_done_o;

    sargantana_icache_way_writer #(
        .ICACHE_DEPTH(DEPTH), .SET_WIDHT(SW), .ADDR_WIDHT(AW),
        .BEAT_WIDTH(BW), .WAYS(WAYS)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .fill_start_i(fill_start_i), .fill_addr_i(fill_addr_i), .fill_way_i(fill_way_i),
        .beat_valid_i(beat_valid_i), .beat_data_i(beat_data_i), .beat_ready_o(beat_ready_o),
        .kill_i(kill_i), .flush_i(flush_i), .ready_o(ready_o),
        .way_req_o(way_req_o), .way_we_o(way_we_o), .way_addr_o(way_addr_o),
        .way_data_o(way_data_o), .fill_done_o(fill_done_o), .flush_done_o(flush_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              c;
        logic [WAYS-1:0] req;
        logic [WAYS-1:0] we;
        logic [AW-1:0]   addr;
        logic [SW-1:0]   data;
        logic            fd;
        logic            xd;
    } ev_t;
    ev_t evq[$];

    always @(negedge clk) begin
        if (rstn_i && ((way_req_o != 0) || (way_we_o != 0) || fill_done_o || flush_done_o)) begin
            evq.push_back('{cyc, way_req_o, way_we_o, way_addr_o, way_data_o, fill_done_o, flush_done_o});
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] beat_v[NB];
    int            gap_v[NB];
    int            kill_at  = -1;
    int            flush_at = -1;
    int            t_start, t_last;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_gaps();
        for (int k = 0; k < NB; k++) gap_v[k] = 0;
    endtask

    task automatic rand_beats();
        for (int k = 0; k < NB; k++) beat_v[k] = {$urandom, $urandom};
    endtask

    // Reference line: beat k occupies bits [k*BW +: BW].
    function automatic logic [SW-1:0] model_line();
        logic [SW-1:0] l;
        l = '0;
        for (int k = 0; k < NB; k++) l = l | ({{(SW-BW){1'b0}}, beat_v[k]} << (k * BW));
        return l;
    endfunction

    task automatic drive_fill(input logic [AW-1:0] a, input logic [WAYS-1:0] m);
        int stop;
        stop = 0;
        fill_start_i = 1'b1; fill_addr_i = a; fill_way_i = m;
        t_start = cyc;
        tick();
        fill_start_i = 1'b0;
        for (int k = 0; k < NB && stop == 0; k++) begin
            repeat (gap_v[k]) tick();
            beat_valid_i = 1'b1;
            beat_data_i  = beat_v[k];
            kill_i       = (k == kill_at);
            flush_i      = (k == flush_at);
            t_last = cyc;
            tick();
            beat_valid_i = 1'b0;
            kill_i       = 1'b0;
            flush_i      = 1'b0;
            if (k == kill_at) stop = 1;
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        #3;
        n_checks++;
        if ({ready_o, beat_ready_o, way_req_o, way_we_o, fill_done_o, flush_done_o} !== {1'b1, 11'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b brdy=%b req=%b we=%b fd=%b xd=%b, need rdy=1 rest 0",
                     ready_o, beat_ready_o, way_req_o, way_we_o, fill_done_o, flush_done_o);
        end
        n_checks++;
        if ({way_addr_o, way_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%0d data=%h, need 0", way_addr_o, way_data_o);
        end
        repeat (2) tick();
        @(negedge clk);
        rstn_i = 1'b1;
        tick();
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b need 1", ready_o);
        end
        $display("reset: ready=%b req=%b", ready_o, way_req_o);
    endtask

    // Check that exactly one line write was seen, one cycle after the last beat.
    task automatic test_one_fill(input string name, input logic [AW-1:0] a, input logic [WAYS-1:0] m, input int exp_cyc);
        logic [SW-1:0] exp_line;
        exp_line = model_line();
        evq.delete();
        drive_fill(a, m);
        tick();
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_after_write: got %b need 1", name, ready_o);
        end
        repeat (3) tick();
        n_checks++;
        if (evq.size() != 1) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d need 1", name, evq.size());
        end else begin
            n_checks++;
            if (evq[0].c != exp_cyc || evq[0].c != t_last + 1) begin
                n_fail++;
                $display("FAIL %s_write_cycle: got %0d need %0d", name, evq[0].c - t_start, exp_cyc - t_start);
            end
            n_checks++;
            if ({evq[0].req, evq[0].we, evq[0].addr, evq[0].fd, evq[0].xd} !== {m, m, a, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL %s_write_ctrl: got req=%b we=%b addr=%0d fd=%b xd=%b need req=we=%b addr=%0d fd=1 xd=0",
                         name, evq[0].req, evq[0].we, evq[0].addr, evq[0].fd, evq[0].xd, m, a);
            end
            n_checks++;
            if (evq[0].data !== exp_line) begin
                n_fail++;
                $display("FAIL %s_write_data: got %h need %h", name, evq[0].data, exp_line);
            end
        end
        $display("fill %s: addr=%0d mask=%b start=%0d last_beat=%0d writes=%0d", name, a, m, t_start, t_last, evq.size());
    endtask

    task automatic test_fill_directed();
        clear_gaps();
        for (int k = 0; k < NB; k++) beat_v[k] = 64'h1111_1111_1111_1111 * k;
        test_one_fill("b2b", 6'd5, 4'b0010, cyc + NB + 1);
        gap_v[1] = 1; gap_v[2] = 1; gap_v[3] = 1;
        test_one_fill("gapped", 6'd5, 4'b0010, cyc + 8);
        clear_gaps();
    endtask

    task automatic test_fill_random();
        logic [AW-1:0]   a;
        logic [WAYS-1:0] m;
        int              span;
        for (int it = 0; it < 10; it++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            m = (it == 0) ? 4'b0000 : (it == 1) ? 4'b1111 : WAYS'($urandom);
            span = 1;
            for (int k = 0; k < NB; k++) begin
                gap_v[k] = $urandom_range(0, 2);
                span += gap_v[k] + 1;
            end
            rand_beats();
            test_one_fill("rand", a, m, cyc + span);
        end
        clear_gaps();
    endtask

    task automatic test_kill();
        for (int k = 0; k < NB; k++) begin
            evq.delete();
            rand_beats();
            kill_at = k;
            drive_fill(AW'($urandom), 4'b1111);
            kill_at = -1;
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL kill_ready: kill at beat %0d, got ready=%b need 1", k, ready_o);
            end
            repeat (4) tick();
            n_checks++;
            if (evq.size() != 0) begin
                n_fail++;
                $display("FAIL kill_no_write: kill at beat %0d, got %0d way events need 0", k, evq.size());
            end
            $display("kill: at beat %0d events=%0d", k, evq.size());
            rand_beats();
            test_one_fill("after_kill", AW'($urandom), 4'b0100, cyc + NB + 1);
        end
    endtask

    // Check nsw back-to-back sweeps; sweep s starts at first + s*(DEPTH+1).
    task automatic check_sweeps(input string name, input int base, input int first, input int nsw);
        int idx, s;
        n_checks++;
        if (evq.size() != base + nsw * DEPTH) begin
            n_fail++;
            $display("FAIL %s_sweep_count: got %0d events need %0d", name, evq.size(), base + nsw * DEPTH);
        end else begin
            for (int i = 0; i < nsw * DEPTH; i++) begin
                idx = i % DEPTH;
                s   = i / DEPTH;
                n_checks++;
                if (evq[base+i].c != first + s * (DEPTH + 1) + idx ||
                    {evq[base+i].req, evq[base+i].we, evq[base+i].addr, evq[base+i].data, evq[base+i].fd, evq[base+i].xd}
                    !== {4'b1111, 4'b1111, AW'(idx), {SW{1'b0}}, 1'b0, (idx == DEPTH - 1)}) begin
                    n_fail++;
                    $display("FAIL %s_sweep_write: entry %0d got cyc=%0d req=%b we=%b addr=%0d data_nz=%b fd=%b xd=%b need cyc=%0d addr=%0d xd=%b",
                             name, i, evq[base+i].c, evq[base+i].req, evq[base+i].we, evq[base+i].addr,
                             |evq[base+i].data, evq[base+i].fd, evq[base+i].xd,
                             first + s * (DEPTH + 1) + idx, idx, (idx == DEPTH - 1));
                end
            end
        end
    endtask

    task automatic test_flush();
        int t;
        evq.delete();
        flush_i = 1'b1; t = cyc; tick(); flush_i = 1'b0;
        repeat (DEPTH - 1) tick();
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got ready=%b need 0 on last sweep cycle", ready_o);
        end
        tick();
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle: got ready=%b need 1 at T+%0d", ready_o, DEPTH + 1);
        end
        repeat (4) tick();
        check_sweeps("flush", 0, t + 1, 1);
        $display("flush: start=%0d events=%0d", t, evq.size());

        // A second request mid-sweep queues exactly one more full sweep.
        evq.delete();
        flush_i = 1'b1; t = cyc; tick(); flush_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        repeat (2 * DEPTH + 10) tick();
        check_sweeps("reflush", 0, t + 1, 2);
        $display("reflush: start=%0d events=%0d", t, evq.size());
    endtask

    task automatic test_flush_collect();
        logic [SW-1:0] exp_line;
        int            w, t2;
        evq.delete();
        clear_gaps();
        rand_beats();
        exp_line = model_line();
        flush_at = 1;
        drive_fill(6'd9, 4'b1000);
        flush_at = -1;
        w = t_last + 1;
        repeat (DEPTH + 8) tick();
        n_checks++;
        if (evq.size() < 1 || evq[0].c != w || evq[0].data !== exp_line || evq[0].fd !== 1'b1 || evq[0].req !== 4'b1000) begin
            n_fail++;
            $display("FAIL flush_collect_fill: events=%0d need fill write at cyc %0d mask 1000", evq.size(), w);
        end
        check_sweeps("flush_collect", 1, w + 2, 1);
        $display("flush_in_collect: fill_write=%0d events=%0d", w, evq.size());

        // fill_start_i together with flush_i in IDLE is dropped.
        evq.delete();
        fill_start_i = 1'b1; fill_addr_i = 6'd33; fill_way_i = 4'b0001; flush_i = 1'b1;
        t2 = cyc; tick();
        fill_start_i = 1'b0; flush_i = 1'b0;
        repeat (DEPTH + 8) tick();
        check_sweeps("flush_vs_fill", 0, t2 + 1, 1);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_vs_fill_idle: got ready=%b need 1", ready_o);
        end
        $display("flush_with_fill_start: start=%0d events=%0d", t2, evq.size());
    endtask

    task automatic test_reset_mid();
        // Mid-fill with a pending flush: nothing may follow the reset.
        clear_gaps();
        rand_beats();
        fill_start_i = 1'b1; fill_addr_i = 6'd12; fill_way_i = 4'b1111; tick(); fill_start_i = 1'b0;
        beat_valid_i = 1'b1; beat_data_i = beat_v[0]; tick();
        beat_data_i = beat_v[1]; flush_i = 1'b1; tick();
        beat_data_i = beat_v[2]; flush_i = 1'b0; tick();
        beat_valid_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({ready_o, beat_ready_o, way_req_o, fill_done_o, flush_done_o} !== {1'b1, 7'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_fill: got rdy=%b brdy=%b req=%b fd=%b xd=%b need rdy=1 rest 0",
                     ready_o, beat_ready_o, way_req_o, fill_done_o, flush_done_o);
        end
        evq.delete();
        @(negedge clk); rstn_i = 1'b1;
        // One more beat after reset must not complete the abandoned line.
        beat_valid_i = 1'b1; tick(); beat_valid_i = 1'b0;
        repeat (DEPTH + 8) tick();
        n_checks++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_fill_quiet: got %0d way events need 0", evq.size());
        end
        $display("reset_mid_fill: events=%0d", evq.size());

        // Mid-flush.
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        repeat (10) tick();
        #2 rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({ready_o, way_req_o, way_we_o, flush_done_o} !== {1'b1, 9'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got rdy=%b req=%b we=%b xd=%b need rdy=1 rest 0",
                     ready_o, way_req_o, way_we_o, flush_done_o);
        end
        evq.delete();
        @(negedge clk); rstn_i = 1'b1;
        repeat (DEPTH + 8) tick();
        n_checks++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_flush_quiet: got %0d way events need 0", evq.size());
        end
        $display("reset_mid_flush: events=%0d", evq.size());
    endtask

    initial begin
        clear_gaps();
        test_reset();
        test_fill_directed();
        test_fill_random();
        test_kill();
        test_flush();
        test_flush_collect();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
